spk_out_arb: RTL and testbench



---
 rtl/spk_pkg.sv | 36 +++
 rtl/rr_arb_pick.sv | 42 ++++
 rtl/spk_out_arb.sv | 203 ++++++++++++++++++++
 tb/tb_spk_out_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spk_pkg.sv
// Shared spike-node definitions: flit type codes, default widths, arbiter FSM states.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package spk_pkg;

  // Default geometry of a node flit: FW bits total, type in the top FTW bits.
  localparam int FW_DEF   = 59;
  localparam int FTW_DEF  = 3;
  localparam int NREQ_DEF = 4;
  // Source index width: soma sources 0..NREQ-1 plus the config source NREQ.
  localparam int SW_DEF   = 3;

  typedef logic [2:0] ftype_t;

  localparam ftype_t SPIKE    = 3'b000;
  localparam ftype_t DATA     = 3'b001;
  localparam ftype_t DATA_END = 3'b010;
  localparam ftype_t WRITE    = 3'b110;
  localparam ftype_t READ     = 3'b111;

  // Output arbiter FSM: IDLE arbitrates freely, LOCK pins the grant to the
  // source of an open multi-flit packet.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  // True for types that open or continue a multi-flit packet.
  function automatic logic opens_packet(input ftype_t t);
    return (t == DATA);
  endfunction

  // True for the type that legally closes a multi-flit packet.
  function automatic logic closes_packet(input ftype_t t);
    return (t == DATA_END);
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin pick: first asserted request scanning upward from ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own ready/stall logic.
//
// Ports:
//   req_i  NREQ-bit request vector
//   ptr_i  index that has highest priority this cycle
//   gnt_o  one-hot grant (all zero when no request)
//   idx_o  binary index of the granted request (0 when no request)
//   any_o  at least one request is asserted
module rr_arb_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  logic          found;
  logic [PW-1:0] cand;

  assign any_o = |req_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/spk_out_arb.sv
// Spike-out fifo push arbiter: NREQ round-robin soma sources plus a bounded-priority config source.
// Latency: 1 cycle from accept (valid & ready) to push/push_data.
// Backpressure: fifo_almost_full drops every ready; an open DATA..DATA_END packet keeps its lock.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    per-soma handshake, req_data holds flit i at [i*FW +: FW]
//   cfg_valid/ready    config handshake, cfg_data is its flit
//   fifo_almost_full   downstream fifo cannot take a push this cycle
//   push, push_data    registered fifo write strobe and data
//   proto_err          one-cycle pulse, aligned with push, on a packet framing violation
module spk_out_arb
  import spk_pkg::*;
#(
  parameter int NREQ          = NREQ_DEF,
  parameter int FW            = FW_DEF,
  parameter int FTW           = FTW_DEF,
  parameter int MAX_CFG_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*FW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               cfg_valid,
  input  logic [FW-1:0]      cfg_data,
  output logic               cfg_ready,
  input  logic               fifo_almost_full,
  output logic               push,
  output logic [FW-1:0]      push_data,
  output logic               proto_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(NREQ + 1);
  localparam int CW = $clog2(MAX_CFG_BURST + 1);

  localparam logic [SW-1:0] CFG_SRC   = SW'(NREQ);
  localparam logic [CW-1:0] CFG_LIMIT = CW'(MAX_CFG_BURST);

  // State
  logic [0:0]    state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cfg_cnt_q, cfg_cnt_d;
  logic [SW-1:0] owner_q, owner_d;
  logic          push_q, push_d;
  logic [FW-1:0] push_data_q, push_data_d;
  logic          proto_err_q, proto_err_d;

  // Arbitration
  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            soma_any;
  logic            cfg_under;
  logic [NREQ-1:0] owner_oh;

  // Accept path
  logic [NREQ-1:0] soma_acc;
  logic            cfg_acc;
  logic            acc;
  logic [FW-1:0]   acc_data;
  logic [SW-1:0]   acc_src;
  logic [FTW-1:0]  acc_type;
  ftype_t          acc_ftype;

  rr_arb_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (soma_any)
  );

  // Config keeps priority only while it has not yet used up its burst
  // allowance against pending soma traffic.
  assign cfg_under = (cfg_cnt_q < CFG_LIMIT);

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_oh[i] = (owner_q == SW'(i));
    end
  end

  // Ready generation. Readies are qualified by valid so at most one is high,
  // and none are raised while the fifo is full or the block is in reset.
  always_comb begin
    req_ready = '0;
    cfg_ready = 1'b0;
    if (!rst && !fifo_almost_full) begin
      if (state_q == S_IDLE) begin
        if (cfg_valid && (!soma_any || cfg_under)) begin
          cfg_ready = 1'b1;
        end else begin
          req_ready = pick_gnt;
        end
      end else begin
        // Locked: only the packet owner may proceed, whoever else is waiting.
        if (owner_q == CFG_SRC) begin
          cfg_ready = cfg_valid;
        end else begin
          req_ready = req_valid & owner_oh;
        end
      end
    end
  end

  assign soma_acc = req_valid & req_ready;
  assign cfg_acc  = cfg_valid & cfg_ready;
  assign acc      = cfg_acc | (|soma_acc);

  // Select the accepted flit and its source index.
  always_comb begin
    acc_data = '0;
    acc_src  = '0;
    if (cfg_acc) begin
      acc_data = cfg_data;
      acc_src  = CFG_SRC;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (soma_acc[i]) begin
          acc_data = req_data[i*FW +: FW];
          acc_src  = SW'(i);
        end
      end
    end
  end

  assign acc_type  = acc_data[FW-1 -: FTW];
  assign acc_ftype = ftype_t'(acc_type);

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    cfg_cnt_d   = cfg_cnt_q;
    push_d      = acc;
    push_data_d = acc ? acc_data : push_data_q;
    proto_err_d = 1'b0;

    if (state_q == S_IDLE) begin
      if (acc) begin
        if (opens_packet(acc_ftype)) begin
          state_d = S_LOCK;
          owner_d = acc_src;
        end else if (closes_packet(acc_ftype)) begin
          // A DATA_END with no open packet is passed through but flagged.
          proto_err_d = 1'b1;
        end
      end

      // In IDLE a soma accept always comes from the round-robin pick.
      if (|soma_acc) begin
        rr_ptr_d = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
      end

      if (!soma_any || (|soma_acc)) begin
        cfg_cnt_d = '0;
      end else if (cfg_acc && (cfg_cnt_q != CFG_LIMIT)) begin
        cfg_cnt_d = cfg_cnt_q + CW'(1);
      end
    end else begin
      // Locked: fairness state is frozen until the packet closes.
      if (acc && !opens_packet(acc_ftype)) begin
        state_d = S_IDLE;
        // Anything other than DATA_END ends the packet abnormally; it is
        // still pushed so no flit is silently lost.
        if (!closes_packet(acc_ftype)) begin
          proto_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cfg_cnt_q   <= '0;
      owner_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cfg_cnt_q   <= cfg_cnt_d;
      owner_q     <= owner_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign push      = push_q;
  assign push_data = push_data_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_spk_out_arb.sv
// Directed bench for spk_out_arb: each step states the expected grant source.
// Latency: expected flits are queued at the accept cycle and compared one cycle later.
// Backpressure: fifo_almost_full steps expect no ready and no push.
module tb_spk_out_arb;
  import spk_pkg::*;

  localparam int NREQ = 4;
  localparam int FW   = 59;
  localparam int CFG  = NREQ;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*FW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               cfg_valid;
  logic [FW-1:0]      cfg_data;
  logic               cfg_ready;
  logic               fifo_almost_full;
  logic               push;
  logic [FW-1:0]      push_data;
  logic               proto_err;

  typedef struct {
    logic [FW-1:0] data;
    logic          perr;
  } sb_t;

  sb_t sbq[$];
  int  errors = 0;
  int  checks = 0;
  int  seqn   = 1;

  spk_out_arb #(
    .NREQ          (NREQ),
    .FW            (FW),
    .FTW           (3),
    .MAX_CFG_BURST (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .cfg_valid        (cfg_valid),
    .cfg_data         (cfg_data),
    .cfg_ready        (cfg_ready),
    .fifo_almost_full (fifo_almost_full),
    .push             (push),
    .push_data        (push_data),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load a fresh, uniquely tagged flit of type t onto source src.
  task automatic setf(input int src, input logic [2:0] t);
    logic [FW-1:0] f;
    f = {t, 24'(src), 32'(seqn)};
    seqn++;
    if (src == CFG) cfg_data = f;
    else req_data[src*FW +: FW] = f;
  endtask

  // After an accept the source presents its next flit: same type, new tag.
  task automatic bump(input int src);
    logic [FW-1:0] f;
    if (src == CFG) f = cfg_data;
    else f = req_data[src*FW +: FW];
    f[31:0] = 32'(seqn);
    seqn++;
    if (src == CFG) cfg_data = f;
    else req_data[src*FW +: FW] = f;
  endtask

  // One arbitration cycle. src = expected accepted source (-1: none),
  // perr = expected proto_err alongside that push.
  task automatic cycle(input int src, input logic perr);
    logic [NREQ:0] exp_rdy;
    sb_t           it;
    @(negedge clk);
    exp_rdy = '0;
    if (src >= 0) exp_rdy[src] = 1'b1;
    chk("ready", 64'({cfg_ready, req_ready}), 64'(exp_rdy));
    if (src >= 0) begin
      it.data = (src == CFG) ? cfg_data : req_data[src*FW +: FW];
      it.perr = perr;
      sbq.push_back(it);
    end
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      it = sbq.pop_front();
      chk("push", 64'(push), 64'(1));
      chk("push_data", 64'(push_data), 64'(it.data));
      chk("proto_err", 64'(proto_err), 64'(it.perr));
    end else begin
      chk("push_idle", 64'(push), 64'(0));
      chk("proto_err_idle", 64'(proto_err), 64'(0));
    end
    if (src >= 0) bump(src);
  endtask

  task automatic drop_all();
    req_valid = '0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    req_valid        = '0;
    req_data         = '0;
    cfg_valid        = 1'b0;
    cfg_data         = '0;
    fifo_almost_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_push", 64'(push), 64'(0));
    chk("rst_push_data", 64'(push_data), 64'(0));
    chk("rst_proto_err", 64'(proto_err), 64'(0));
    rst = 1'b0;

    // Round robin over four always-valid SPIKE sources.
    for (int i = 0; i < NREQ; i++) setf(i, SPIKE);
    req_valid = '1;
    for (int n = 0; n < 8; n++) cycle(n % NREQ, 1'b0);
    drop_all();

    // Config burst limit against a pending soma request.
    setf(CFG, WRITE);
    setf(2, SPIKE);
    req_valid = 4'b0100;
    cfg_valid = 1'b1;
    repeat (4) cycle(CFG, 1'b0);
    cycle(2, 1'b0);
    cycle(CFG, 1'b0);
    drop_all();
    cycle(-1, 1'b0);

    // Req 1 packet stays contiguous while others and config are waiting.
    setf(1, DATA);
    req_valid = 4'b0010;
    cycle(1, 1'b0);
    setf(0, SPIKE);
    setf(3, SPIKE);
    setf(CFG, READ);
    req_valid = 4'b1011;
    cfg_valid = 1'b1;
    cycle(1, 1'b0);
    setf(1, DATA_END);
    cycle(1, 1'b0);
    req_valid = 4'b1001;
    repeat (4) cycle(CFG, 1'b0);
    cycle(3, 1'b0);
    cycle(CFG, 1'b0);
    drop_all();
    cycle(-1, 1'b0);

    // fifo_almost_full in mid-packet: stall, then only the owner resumes.
    setf(1, DATA);
    req_valid = 4'b0010;
    cycle(1, 1'b0);
    fifo_almost_full = 1'b1;
    setf(0, SPIKE);
    req_valid = 4'b0011;
    cfg_valid = 1'b1;
    repeat (3) cycle(-1, 1'b0);
    fifo_almost_full = 1'b0;
    cycle(1, 1'b0);
    setf(1, DATA_END);
    cycle(1, 1'b0);
    cycle(CFG, 1'b0);
    drop_all();
    cycle(-1, 1'b0);

    // Framing violations: DATA then SPIKE from the owner, lone DATA_END.
    setf(3, DATA);
    req_valid = 4'b1000;
    cycle(3, 1'b0);
    setf(3, SPIKE);
    setf(0, SPIKE);
    req_valid = 4'b1001;
    cycle(3, 1'b1);
    cycle(0, 1'b0);
    setf(1, DATA_END);
    req_valid = 4'b0010;
    cycle(1, 1'b1);
    setf(1, SPIKE);
    setf(2, SPIKE);
    req_valid = 4'b0110;
    cycle(2, 1'b0);
    drop_all();
    cycle(-1, 1'b0);

    // Reset while locked abandons the packet and restores arbitration state.
    setf(0, DATA);
    req_valid = 4'b0001;
    cycle(0, 1'b0);
    drop_all();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("lockrst_push", 64'(push), 64'(0));
    chk("lockrst_push_data", 64'(push_data), 64'(0));
    chk("lockrst_proto_err", 64'(proto_err), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) setf(i, SPIKE);
    setf(CFG, WRITE);
    req_valid = '1;
    cfg_valid = 1'b1;
    cycle(CFG, 1'b0);
    cfg_valid = 1'b0;
    cycle(0, 1'b0);
    cycle(1, 1'b0);
    drop_all();
    cycle(-1, 1'b0);

    chk("sb_empty", 64'(sbq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
